// File: rtl/cam_update_sched.sv
// Update scheduler for a LUTRAM CAM bank: serialises insert/invalidate/flush onto
// two-cycle entry updates, tracks validity and qualifies raw entry hits.
module cam_update_sched #(
  parameter int ENTRIES         = 8,
  parameter int PACKS_OF_5_BITS = 4,
  localparam int KEY_W          = 5 * PACKS_OF_5_BITS,
  localparam int IDX_W          = $clog2(ENTRIES)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ins_valid_i,
  output logic               ins_ready_o,
  input  logic [KEY_W-1:0]   ins_key_i,
  output logic [IDX_W-1:0]   ins_idx_o,
  input  logic               inv_valid_i,
  output logic               inv_ready_o,
  input  logic [IDX_W-1:0]   inv_idx_i,
  input  logic               flush_i,
  output logic [ENTRIES-1:0] cam_update_o,
  output logic [KEY_W-1:0]   cam_set_key_o,
  output logic               cam_set_valid_o,
  input  logic [ENTRIES-1:0] cam_hit_i,
  output logic               lookup_hit_o,
  output logic [IDX_W-1:0]   lookup_idx_o,
  output logic               lookup_multi_o,
  output logic               lookup_stall_o,
  output logic               busy_o
);

  typedef enum logic [1:0] {
    ST_INIT   = 2'd0,
    ST_ISSUE  = 2'd1,
    ST_SETTLE = 2'd2,
    ST_IDLE   = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [ENTRIES-1:0] valid_q, valid_d;
  logic [ENTRIES-1:0] update_q, update_d;
  logic [ENTRIES-1:0] mask_q, mask_d;
  logic [KEY_W-1:0]   set_key_q, set_key_d;
  logic               set_valid_q, set_valid_d;
  logic               flush_q, flush_d;
  logic [IDX_W-1:0]   rr_q, rr_d;

  logic [IDX_W-1:0]   victim;
  logic               victim_free;
  logic [ENTRIES-1:0] qual;
  logic [IDX_W-1:0]   hit_idx;
  logic               hit_found;
  logic [ENTRIES-1:0] onehot;
  logic               idle;
  logic               flush_pend;

  assign idle       = (state_q == ST_IDLE);
  assign flush_pend = flush_q | flush_i;

  assign inv_ready_o = idle & ~flush_pend;
  assign ins_ready_o = idle & ~flush_pend & ~inv_valid_i;

  // Lowest invalid entry wins; a full bank falls back to the round-robin pointer.
  always_comb begin
    victim      = rr_q;
    victim_free = 1'b0;
    for (int unsigned i = 0; i < ENTRIES; i++) begin
      if (!victim_free && !valid_q[i]) begin
        victim      = IDX_W'(i);
        victim_free = 1'b1;
      end
    end
  end

  assign ins_idx_o = victim;

  always_comb begin
    qual      = cam_hit_i & valid_q & ~mask_q;
    hit_idx   = '0;
    hit_found = 1'b0;
    for (int unsigned i = 0; i < ENTRIES; i++) begin
      if (!hit_found && qual[i]) begin
        hit_idx   = IDX_W'(i);
        hit_found = 1'b1;
      end
    end
  end

  assign lookup_hit_o   = |qual;
  assign lookup_idx_o   = hit_idx;
  assign lookup_multi_o = |(qual & (qual - ENTRIES'(1)));
  assign lookup_stall_o = ~idle;
  assign busy_o         = ~idle;

  always_comb begin
    state_d     = state_q;
    update_d    = '0;
    mask_d      = mask_q;
    valid_d     = valid_q;
    rr_d        = rr_q;
    set_key_d   = set_key_q;
    set_valid_d = set_valid_q;
    flush_d     = flush_q | flush_i;
    onehot      = '0;
    case (state_q)
      // Reset leaves the strobe register at 0, so the INIT cycle loads the
      // all-ones clear and drives it through the regular ISSUE/SETTLE pair.
      ST_INIT: begin
        update_d    = '1;
        mask_d      = '1;
        set_key_d   = '0;
        set_valid_d = 1'b0;
        state_d     = ST_ISSUE;
      end
      ST_ISSUE: state_d = ST_SETTLE;
      ST_SETTLE: begin
        mask_d  = '0;
        state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (flush_pend) begin
          flush_d     = 1'b0;
          update_d    = '1;
          mask_d      = '1;
          valid_d     = '0;
          set_key_d   = '0;
          set_valid_d = 1'b0;
          state_d     = ST_ISSUE;
        end else if (inv_valid_i) begin
          onehot[inv_idx_i]  = 1'b1;
          update_d           = onehot;
          mask_d             = onehot;
          valid_d[inv_idx_i] = 1'b0;
          set_key_d          = '0;
          set_valid_d        = 1'b0;
          state_d            = ST_ISSUE;
        end else if (ins_valid_i) begin
          onehot[victim]  = 1'b1;
          update_d        = onehot;
          mask_d          = onehot;
          valid_d[victim] = 1'b1;
          set_key_d       = ins_key_i;
          set_valid_d     = 1'b1;
          if (!victim_free) rr_d = rr_q + 1'b1;
          state_d         = ST_ISSUE;
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_INIT;
      valid_q     <= '0;
      update_q    <= '0;
      mask_q      <= '0;
      set_key_q   <= '0;
      set_valid_q <= 1'b0;
      flush_q     <= 1'b0;
      rr_q        <= '0;
    end else begin
      state_q     <= state_d;
      valid_q     <= valid_d;
      update_q    <= update_d;
      mask_q      <= mask_d;
      set_key_q   <= set_key_d;
      set_valid_q <= set_valid_d;
      flush_q     <= flush_d;
      rr_q        <= rr_d;
    end
  end

  assign cam_update_o    = update_q;
  assign cam_set_key_o   = set_key_q;
  assign cam_set_valid_o = set_valid_q;

endmodule

// File: tb/tb_cam_update_sched.sv
// Bench for cam_update_sched: emulated two-cycle CAM entries, a transaction-level
// reference model, a forced-hit vector table and directed corner sequences.
module tb_cam_update_sched;

  localparam int ENTRIES = 8;
  localparam int PACKS   = 4;
  localparam int KEY_W   = 5 * PACKS;
  localparam int IDX_W   = 3;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               ins_valid_i = 1'b0;
  logic               ins_ready_o;
  logic [KEY_W-1:0]   ins_key_i = '0;
  logic [IDX_W-1:0]   ins_idx_o;
  logic               inv_valid_i = 1'b0;
  logic               inv_ready_o;
  logic [IDX_W-1:0]   inv_idx_i = '0;
  logic               flush_i = 1'b0;
  logic [ENTRIES-1:0] cam_update_o;
  logic [KEY_W-1:0]   cam_set_key_o;
  logic               cam_set_valid_o;
  logic [ENTRIES-1:0] cam_hit_i;
  logic               lookup_hit_o;
  logic [IDX_W-1:0]   lookup_idx_o;
  logic               lookup_multi_o;
  logic               lookup_stall_o;
  logic               busy_o;

  always #5 clk = ~clk;

  cam_update_sched #(.ENTRIES(ENTRIES), .PACKS_OF_5_BITS(PACKS)) dut (
    .clk(clk), .rst_n(rst_n),
    .ins_valid_i(ins_valid_i), .ins_ready_o(ins_ready_o), .ins_key_i(ins_key_i),
    .ins_idx_o(ins_idx_o),
    .inv_valid_i(inv_valid_i), .inv_ready_o(inv_ready_o), .inv_idx_i(inv_idx_i),
    .flush_i(flush_i),
    .cam_update_o(cam_update_o), .cam_set_key_o(cam_set_key_o),
    .cam_set_valid_o(cam_set_valid_o), .cam_hit_i(cam_hit_i),
    .lookup_hit_o(lookup_hit_o), .lookup_idx_o(lookup_idx_o),
    .lookup_multi_o(lookup_multi_o), .lookup_stall_o(lookup_stall_o),
    .busy_o(busy_o)
  );

  // Entry array: a strobe clears the entry, the following edge writes the shared key.
  logic [KEY_W-1:0]   ent_key [ENTRIES];
  logic [ENTRIES-1:0] ent_v = '0;
  logic [ENTRIES-1:0] pend_wr = '0;
  logic [ENTRIES-1:0] emu_hit;
  logic [KEY_W-1:0]   lkey = '0;
  logic               force_en = 1'b0;
  logic [ENTRIES-1:0] force_hit = '0;

  always @(posedge clk) begin
    for (int i = 0; i < ENTRIES; i++) begin
      if (pend_wr[i]) begin
        ent_key[i] <= cam_set_key_o;
        ent_v[i]   <= cam_set_valid_o;
        pend_wr[i] <= 1'b0;
      end else if (cam_update_o[i]) begin
        ent_v[i]   <= 1'b0;
        pend_wr[i] <= 1'b1;
      end
    end
  end

  always_comb begin
    emu_hit = '0;
    for (int i = 0; i < ENTRIES; i++) emu_hit[i] = ent_v[i] && (ent_key[i] == lkey);
  end

  assign cam_hit_i = force_en ? force_hit : emu_hit;

  // Reference model: contents as seen by requesters once each operation lands.
  bit                 m_valid [ENTRIES];
  logic [KEY_W-1:0]   m_key   [ENTRIES];
  int                 m_rr;
  int                 m_busy;
  bit                 m_flush;
  logic [ENTRIES-1:0] m_fly;
  logic [KEY_W-1:0]   m_setk;
  bit                 m_setv;

  int n_vec = 0;
  int n_bad = 0;

  logic               obs_ready, obs_inv_ready, obs_hit, obs_multi, obs_stall, obs_setv;
  logic [IDX_W-1:0]   obs_ins_idx, obs_lidx;
  logic [ENTRIES-1:0] obs_update;

  typedef struct {
    logic [ENTRIES-1:0] hit;
    logic               exp_hit;
    logic [IDX_W-1:0]   exp_idx;
    logic               exp_multi;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit model_full();
    for (int i = 0; i < ENTRIES; i++) if (!m_valid[i]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic int model_victim();
    for (int i = 0; i < ENTRIES; i++) if (!m_valid[i]) return i;
    return m_rr;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < ENTRIES; i++) m_valid[i] = 1'b0;
    m_rr    = 0;
    m_flush = 1'b0;
    m_busy  = 3;
    m_fly   = '1;
    m_setk  = '0;
    m_setv  = 1'b0;
  endtask

  task automatic model_check(input bit iv, input bit vv, input bit fl, input logic [KEY_W-1:0] lk);
    bit rdy;
    int cnt;
    int first;
    rdy = (m_busy == 0) && !m_flush && !fl;
    chk("inv_ready", 32'(inv_ready_o), 32'(rdy));
    chk("ins_ready", 32'(ins_ready_o), 32'(rdy && !vv));
    chk("stall", 32'(lookup_stall_o), 32'(m_busy > 0));
    chk("busy", 32'(busy_o), 32'(m_busy > 0));
    chk("strobe", 32'(cam_update_o), (m_busy == 2) ? 32'(m_fly) : 32'd0);
    if (m_busy == 1 || m_busy == 2) begin
      chk("set_key", 32'(cam_set_key_o), 32'(m_setk));
      chk("set_valid", 32'(cam_set_valid_o), 32'(m_setv));
    end
    if (rdy && iv && !vv) chk("ins_idx", 32'(ins_idx_o), 32'(model_victim()));
    if (!force_en) begin
      cnt = 0;
      first = 0;
      for (int i = 0; i < ENTRIES; i++) begin
        if (m_valid[i] && m_key[i] == lk && !(m_busy > 0 && m_fly[i])) begin
          if (cnt == 0) first = i;
          cnt++;
        end
      end
      chk("lookup_hit", 32'(lookup_hit_o), 32'(cnt > 0));
      chk("lookup_idx", 32'(lookup_idx_o), 32'(first));
      chk("lookup_multi", 32'(lookup_multi_o), 32'(cnt > 1));
    end
  endtask

  task automatic model_edge(input bit iv, input logic [KEY_W-1:0] ik, input bit vv,
                            input logic [IDX_W-1:0] vi, input bit fl);
    int v;
    if (m_busy > 0) begin
      m_busy--;
      if (fl) m_flush = 1'b1;
    end else if (m_flush || fl) begin
      m_flush = 1'b0;
      for (int i = 0; i < ENTRIES; i++) m_valid[i] = 1'b0;
      m_fly  = '1;
      m_setk = '0;
      m_setv = 1'b0;
      m_busy = 2;
    end else if (vv) begin
      m_valid[vi] = 1'b0;
      m_fly       = '0;
      m_fly[vi]   = 1'b1;
      m_setk      = '0;
      m_setv      = 1'b0;
      m_busy      = 2;
    end else if (iv) begin
      v = model_victim();
      if (model_full()) m_rr = (m_rr + 1) % ENTRIES;
      m_valid[v] = 1'b1;
      m_key[v]   = ik;
      m_fly      = '0;
      m_fly[v]   = 1'b1;
      m_setk     = ik;
      m_setv     = 1'b1;
      m_busy     = 2;
    end
  endtask

  // One clock cycle: drive after the falling edge, sample 1 time unit later.
  task automatic cycle(input bit iv, input logic [KEY_W-1:0] ik, input bit vv,
                       input logic [IDX_W-1:0] vi, input bit fl, input logic [KEY_W-1:0] lk);
    ins_valid_i = iv;
    ins_key_i   = ik;
    inv_valid_i = vv;
    inv_idx_i   = vi;
    flush_i     = fl;
    lkey        = lk;
    #1;
    obs_ready     = ins_ready_o;
    obs_inv_ready = inv_ready_o;
    obs_ins_idx   = ins_idx_o;
    obs_update    = cam_update_o;
    obs_setv      = cam_set_valid_o;
    obs_hit       = lookup_hit_o;
    obs_lidx      = lookup_idx_o;
    obs_multi     = lookup_multi_o;
    obs_stall     = lookup_stall_o;
    model_check(iv, vv, fl, lk);
    @(posedge clk);
    model_edge(iv, ik, vv, vi, fl);
    @(negedge clk);
  endtask

  task automatic idle(input int n, input logic [KEY_W-1:0] lk);
    for (int i = 0; i < n; i++) cycle(1'b0, '0, 1'b0, '0, 1'b0, lk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t               tbl [7];
    logic [KEY_W-1:0]   k0, kx, ky, kn, kf, kr, keyctr, lk;
    bit                 iv, vv, fl;
    logic [IDX_W-1:0]   vi;

    k0 = 20'h12345; kx = 20'hAAAA1; ky = 20'hBBBB2;
    kn = 20'h33333; kf = 20'h44444; kr = 20'h55555;
    for (int i = 0; i < ENTRIES; i++) m_key[i] = '0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Reset release: INIT, all-ones clear, settle, then ready.
    idle(1, k0);
    chk("rst_c0_ready", 32'(obs_ready), 32'd0);
    chk("rst_c0_stall", 32'(obs_stall), 32'd1);
    idle(1, k0);
    chk("rst_c1_strobe", 32'(obs_update), 32'hFF);
    chk("rst_c1_setv", 32'(obs_setv), 32'd0);
    chk("rst_c1_stall", 32'(obs_stall), 32'd1);
    idle(1, k0);
    chk("rst_c2_strobe", 32'(obs_update), 32'd0);
    chk("rst_c2_stall", 32'(obs_stall), 32'd1);
    idle(1, k0);
    chk("rst_c3_ready", 32'(obs_ready), 32'd1);
    chk("rst_c3_stall", 32'(obs_stall), 32'd0);

    // First insert on an empty bank.
    cycle(1'b1, k0, 1'b0, '0, 1'b0, k0);
    chk("ins0_idx", 32'(obs_ins_idx), 32'd0);
    idle(1, k0);
    chk("ins0_t1_strobe", 32'(obs_update), 32'h01);
    chk("ins0_t1_hit", 32'(obs_hit), 32'd0);
    idle(1, k0);
    chk("ins0_t2_strobe", 32'(obs_update), 32'd0);
    chk("ins0_t2_hit", 32'(obs_hit), 32'd0);
    idle(1, k0);
    chk("ins0_t3_hit", 32'(obs_hit), 32'd1);
    chk("ins0_t3_idx", 32'(obs_lidx), 32'd0);

    // Fill the bank, then round-robin replacement.
    for (int k = 1; k < ENTRIES; k++) begin
      cycle(1'b1, KEY_W'(32'h01000 + k), 1'b0, '0, 1'b0, k0);
      chk("fill_idx", 32'(obs_ins_idx), 32'(k));
      idle(2, k0);
    end
    cycle(1'b1, kx, 1'b0, '0, 1'b0, k0);
    chk("rr0_idx", 32'(obs_ins_idx), 32'd0);
    force_en = 1'b1; force_hit = 8'h03;
    idle(1, k0);
    chk("mask_hit", 32'(obs_hit), 32'd1);
    chk("mask_idx", 32'(obs_lidx), 32'd1);
    chk("mask_multi", 32'(obs_multi), 32'd0);
    force_en = 1'b0;
    idle(1, k0);
    cycle(1'b1, ky, 1'b0, '0, 1'b0, k0);
    chk("rr1_idx", 32'(obs_ins_idx), 32'd1);
    chk("old_key_miss", 32'(obs_hit), 32'd0);
    idle(2, kx);
    idle(1, kx);
    chk("rr0_key_hit", 32'(obs_hit), 32'd1);
    chk("rr0_key_idx", 32'(obs_lidx), 32'd0);

    // Qualification table on a full, quiescent bank.
    tbl[0] = '{8'h00, 1'b0, 3'd0, 1'b0};
    tbl[1] = '{8'h01, 1'b1, 3'd0, 1'b0};
    tbl[2] = '{8'h80, 1'b1, 3'd7, 1'b0};
    tbl[3] = '{8'h0A, 1'b1, 3'd1, 1'b1};
    tbl[4] = '{8'hFF, 1'b1, 3'd0, 1'b1};
    tbl[5] = '{8'h40, 1'b1, 3'd6, 1'b0};
    tbl[6] = '{8'h0C, 1'b1, 3'd2, 1'b1};
    force_en = 1'b1;
    for (int t = 0; t < 7; t++) begin
      force_hit = tbl[t].hit;
      idle(1, '0);
      chk("tbl_hit", 32'(obs_hit), 32'(tbl[t].exp_hit));
      chk("tbl_idx", 32'(obs_lidx), 32'(tbl[t].exp_idx));
      chk("tbl_multi", 32'(obs_multi), 32'(tbl[t].exp_multi));
    end
    force_en = 1'b0;

    // Invalidate then insert: the freed slot is reused.
    cycle(1'b0, '0, 1'b1, 3'd3, 1'b0, '0);
    chk("inv_ready", 32'(obs_inv_ready), 32'd1);
    cycle(1'b1, kn, 1'b0, '0, 1'b0, '0);
    chk("inv_t1_ready", 32'(obs_ready), 32'd0);
    force_en = 1'b1; force_hit = 8'h18;
    cycle(1'b1, kn, 1'b0, '0, 1'b0, '0);
    chk("inv_t2_ready", 32'(obs_ready), 32'd0);
    chk("inv_t2_idx", 32'(obs_lidx), 32'd4);
    force_en = 1'b0;
    cycle(1'b1, kn, 1'b0, '0, 1'b0, '0);
    chk("inv_t3_ready", 32'(obs_ready), 32'd1);
    chk("reuse_idx", 32'(obs_ins_idx), 32'd3);
    idle(2, kn);
    idle(1, kn);
    chk("reuse_hit_idx", 32'(obs_lidx), 32'd3);

    // Flush beats a simultaneous insert.
    cycle(1'b1, kf, 1'b0, '0, 1'b1, kn);
    chk("fl_ins_ready", 32'(obs_ready), 32'd0);
    cycle(1'b1, kf, 1'b0, '0, 1'b0, kn);
    chk("fl_strobe", 32'(obs_update), 32'hFF);
    chk("fl_setv", 32'(obs_setv), 32'd0);
    cycle(1'b1, kf, 1'b0, '0, 1'b0, kn);
    cycle(1'b1, kf, 1'b0, '0, 1'b0, kn);
    chk("fl_t3_ready", 32'(obs_ready), 32'd1);
    chk("fl_t3_idx", 32'(obs_ins_idx), 32'd0);
    idle(2, kf);

    // Reset during SETTLE abandons the insert.
    cycle(1'b1, kr, 1'b0, '0, 1'b0, kr);
    chk("rs_idx", 32'(obs_ins_idx), 32'd1);
    idle(1, kr);
    ins_valid_i = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rs_strobe", 32'(cam_update_o), 32'd0);
    chk("rs_set_key", 32'(cam_set_key_o), 32'd0);
    chk("rs_set_valid", 32'(cam_set_valid_o), 32'd0);
    chk("rs_hit", 32'(lookup_hit_o), 32'd0);
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    idle(5, kr);
    chk("rs_never_hits", 32'(obs_hit), 32'd0);

    // Randomised traffic against the model.
    keyctr = 20'h40000;
    for (int n = 0; n < 1500; n++) begin
      iv = ($urandom_range(0, 9) < 4);
      vv = ($urandom_range(0, 19) < 3);
      vi = IDX_W'($urandom_range(0, ENTRIES - 1));
      fl = ($urandom_range(0, 49) == 0);
      keyctr = keyctr + 1'b1;
      if ($urandom_range(0, 3) < 3) lk = m_key[$urandom_range(0, ENTRIES - 1)];
      else lk = KEY_W'($urandom);
      cycle(iv, keyctr, vv, vi, fl, lk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
